// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Arbitrates the single shared RAM port between instruction fetch (imem*) and
// data access (dmem*) requests. Accesses are serialised through a four-state
// FSM (IDLE -> IACC/DACC -> DONE -> IDLE). Data requests win over instruction
// requests. Completion is reported with one-cycle ihit/dhit pulses, and load
// data is held in registers until the next completed read for that port.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_EN):
//   When defined, a saturating counter tracks consecutive data grants made
//   while an instruction request waits. Once it reaches STARVE_MAX, the next
//   IDLE arbitration grants the instruction side. When undefined, arbitration
//   uses strict data priority and no counter exists.
//
// Parameters:
//   WORD_W      data/address width
//   STARVE_MAX  data grants tolerated while an instruction request waits
//               (MEM_ARB_STARVE_EN only)
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   imemREN, imemaddr    instruction read request / address (held until ihit)
//   imemload, ihit       registered instruction data / completion pulse
//   dmemREN, dmemWEN     data read / write request (held until dhit)
//   dmemaddr, dmemstore  data address / write data
//   dmemload, dhit       registered read data / completion pulse
//   halt                 blocks new instruction grants
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload, ram_ready   RAM read data / access-complete indication
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int WORD_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic [WORD_W-1:0] imemload,
   output logic              ihit,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic [WORD_W-1:0] dmemaddr,
   input  logic [WORD_W-1:0] dmemstore,
   output logic [WORD_W-1:0] dmemload,
   output logic              dhit,
   input  logic              halt,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ram_ready
);

   typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   state_t            state_q;
   owner_t            owner_q;
   logic              wr_q;
   logic              ren_q;
   logic              wen_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] store_q;
   logic [WORD_W-1:0] iload_q;
   logic [WORD_W-1:0] dload_q;

   logic d_req;
   logic i_req;
   logic grant_i;
   logic grant_d;

   assign d_req = dmemREN | dmemWEN;
   assign i_req = imemREN & ~halt;

`ifdef MEM_ARB_STARVE_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;
   logic             starved;

   assign starved = (starve_q == CNT_W'(STARVE_MAX));
   // A starved instruction request overrides data priority for one grant.
   assign grant_i = i_req & (~d_req | starved);

   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (grant_i) begin
            starve_d = '0;
         end else if (grant_d && i_req && !starved) begin
            starve_d = starve_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign grant_i = i_req & ~d_req;
`endif

   assign grant_d = d_req & ~grant_i;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
         wr_q    <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  // REN and WEN together are treated as a write.
                  state_q <= DACC;
                  owner_q <= OWN_D;
                  wr_q    <= dmemWEN;
                  ren_q   <= ~dmemWEN;
                  wen_q   <= dmemWEN;
                  addr_q  <= dmemaddr;
                  store_q <= dmemstore;
               end else if (grant_i) begin
                  state_q <= IACC;
                  owner_q <= OWN_I;
                  wr_q    <= 1'b0;
                  ren_q   <= 1'b1;
                  wen_q   <= 1'b0;
                  addr_q  <= imemaddr;
               end
            end
            IACC, DACC: begin
               // Accesses run to completion even if the request is withdrawn.
               if (ram_ready) begin
                  state_q <= DONE;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  if (!wr_q) begin
                     if (owner_q == OWN_I) begin
                        iload_q <= ramload;
                     end else begin
                        dload_q <= ramload;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The hit is gated by the live request so a fetch withdrawn during the
   // access (a flush) completes on the RAM without reporting a hit.
   assign ihit = (state_q == DONE) && (owner_q == OWN_I) && imemREN;
   assign dhit = (state_q == DONE) && (owner_q == OWN_D) && d_req;

   assign ramREN   = ren_q;
   assign ramWEN   = wen_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign imemload = iload_q;
   assign dmemload = dload_q;

endmodule
